// File: rtl/if_fetch_stage_if.sv
// rtl/if_fetch_stage_if.sv - instruction-memory and decode handshake bundle for the fetch stage
interface if_fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;

    modport master (
        output imem_req, imem_addr, if_valid, if_instr, if_pc,
        input  imem_ready, imem_rvalid, imem_rdata, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_instr, if_pc,
        output imem_ready, imem_rvalid, imem_rdata, id_ready
    );
endinterface

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - MIPS instruction-fetch stage with PC register, single-outstanding fetch and decode handoff
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    if_fetch_stage_if.master   bus,
    input  logic [31:0]        npc_in,
    output logic [31:0]        pc_out,
    input  logic               flush,
    input  logic [31:0]        flush_pc,
    output logic [31:0]        fetch_count
);
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DRAIN} state_t;

    state_t      state, next_state;
    logic [31:0] pc;
    logic        valid_q;
    logic [31:0] instr_q;
    logic [31:0] ipc_q;
    logic [31:0] count_q;
    logic        handshake;
    logic        capture;

    assign handshake = (state == S_HOLD) && valid_q && bus.id_ready && !flush;
    assign capture   = (state == S_WAIT) && bus.imem_rvalid && !flush;

    assign bus.imem_req  = (state == S_REQ);
    assign bus.imem_addr = pc;
    assign bus.if_valid  = valid_q;
    assign bus.if_instr  = instr_q;
    assign bus.if_pc     = ipc_q;
    assign pc_out        = pc;
    assign fetch_count   = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  next_state = S_REQ;
            // An accepted request leaves a response in flight, flushed or not
            S_REQ:   if (bus.imem_ready)     next_state = flush ? S_DRAIN : S_WAIT;
            S_WAIT:  if (flush)              next_state = bus.imem_rvalid ? S_REQ : S_DRAIN;
                     else if (bus.imem_rvalid) next_state = S_HOLD;
            S_HOLD:  if (flush || handshake) next_state = S_REQ;
            S_DRAIN: if (bus.imem_rvalid)    next_state = S_REQ;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= RESET_PC;
            valid_q <= 1'b0;
            instr_q <= 32'h0;
            ipc_q   <= 32'h0;
            count_q <= 32'h0;
        end else if (flush) begin
            pc      <= flush_pc;
            valid_q <= 1'b0;
        end else if (capture) begin
            instr_q <= bus.imem_rdata;
            ipc_q   <= pc;
            valid_q <= 1'b1;
        end else if (handshake) begin
            pc      <= npc_in;
            valid_q <= 1'b0;
            count_q <= count_q + 32'd1;
        end
    end
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - directed scoreboard bench for if_fetch_stage
module tb_if_fetch_stage;
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instr;
    } sb_entry_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] npc_in;
    logic [31:0] pc_out;
    logic        flush;
    logic [31:0] flush_pc;
    logic [31:0] fetch_count;
    logic        br_en;
    logic [31:0] br_target;

    int          n_assert = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          hs_cyc = 0;
    int          prev_hs = 0;
    logic [31:0] exp_count = 0;
    logic        saw_stale = 1'b0;
    sb_entry_t   sb[$];

    if_fetch_stage_if bus();

    if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .npc_in      (npc_in),
        .pc_out      (pc_out),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .fetch_count (fetch_count)
    );

    // Next-PC block model: PC+4 unless a branch is being taken
    assign npc_in = br_en ? br_target : pc_out + 32'd4;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.if_valid && bus.if_instr == 32'hDEADBEEF) saw_stale <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input logic [31:0] exp_addr);
        int n = 0;
        while (!bus.imem_req && n < 20) begin
            step();
            n++;
        end
        chk("req_seen", 32'(bus.imem_req), 32'd1);
        chk("req_addr", bus.imem_addr, exp_addr);
    endtask

    task automatic fetch_to_hold(input logic [31:0] addr, input logic [31:0] instr, input int rdelay);
        wait_req(addr);
        for (int i = 0; i < rdelay; i++) begin
            bus.imem_ready  = 1'b0;
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = 32'hBAD0_0000 | 32'(i);
            step();
            chk("bp_req", 32'(bus.imem_req), 32'd1);
            chk("bp_addr", bus.imem_addr, addr);
            chk("bp_valid", 32'(bus.if_valid), 32'd0);
        end
        bus.imem_rvalid = 1'b0;
        bus.imem_ready  = 1'b1;
        step();
        bus.imem_ready = 1'b0;
        chk("wait_req_low", 32'(bus.imem_req), 32'd0);
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = instr;
        sb.push_back('{addr: addr, instr: instr});
        step();
        bus.imem_rvalid = 1'b0;
        chk("valid_latency", 32'(bus.if_valid), 32'd1);
    endtask

    task automatic handshake(input int stall, input logic br, input logic [31:0] target);
        logic [31:0] s_instr, s_pc, s_pcout, exp_npc;
        sb_entry_t   e;
        s_instr = bus.if_instr;
        s_pc    = bus.if_pc;
        s_pcout = pc_out;
        bus.id_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            step();
            chk("stall_instr", bus.if_instr, s_instr);
            chk("stall_ifpc", bus.if_pc, s_pc);
            chk("stall_pc", pc_out, s_pcout);
            chk("stall_req", 32'(bus.imem_req), 32'd0);
            chk("stall_count", fetch_count, exp_count);
        end
        exp_npc   = br ? target : s_pcout + 32'd4;
        br_en     = br;
        br_target = target;
        bus.id_ready = 1'b1;
        chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("sb_if_pc", bus.if_pc, e.addr);
            chk("sb_if_instr", bus.if_instr, e.instr);
        end
        prev_hs = hs_cyc;
        hs_cyc  = cyc;
        step();
        bus.id_ready = 1'b0;
        br_en = 1'b0;
        exp_count++;
        chk("hs_count", fetch_count, exp_count);
        chk("hs_valid_low", 32'(bus.if_valid), 32'd0);
        chk("hs_req_next", 32'(bus.imem_req), 32'd1);
        chk("hs_next_addr", bus.imem_addr, exp_npc);
    endtask

    task automatic fetch_one(input logic [31:0] addr, input logic [31:0] instr, input int rdelay, input int stall,
                             input logic br, input logic [31:0] target);
        fetch_to_hold(addr, instr, rdelay);
        handshake(stall, br, target);
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        flush_pc = 32'h0;
        br_en = 1'b0;
        br_target = 32'h0;
        bus.imem_ready = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata = 32'h0;
        bus.id_ready = 1'b0;
        #12;
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_addr", bus.imem_addr, 32'h0);
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_valid", 32'(bus.if_valid), 32'd0);
        chk("rst_instr", bus.if_instr, 32'h0);
        chk("rst_ifpc", bus.if_pc, 32'h0);
        chk("rst_count", fetch_count, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Sequential fetch, best-case timing
        for (int i = 0; i < 4; i++) begin
            fetch_one(32'(i * 4), 32'h1000_0000 + 32'(i), 0, 0, 1'b0, 32'h0);
            if (i > 0) chk("hs_spacing", 32'(hs_cyc - prev_hs), 32'd3);
        end
        chk("count_after_4", fetch_count, 32'd4);

        // Branch taken at 0x10
        fetch_one(32'h10, 32'h1000_0010, 0, 0, 1'b1, 32'h40);
        fetch_one(32'h40, 32'h1000_0040, 0, 0, 1'b0, 32'h0);

        // Decode stall, then memory backpressure with ignored rvalid in REQ
        fetch_one(32'h44, 32'h1000_0044, 0, 5, 1'b0, 32'h0);
        fetch_one(32'h48, 32'h1000_0048, 4, 0, 1'b0, 32'h0);

        // Flush in WAIT, stale response drained
        wait_req(32'h4C);
        bus.imem_ready = 1'b1;
        step();
        bus.imem_ready = 1'b0;
        flush = 1'b1;
        flush_pc = 32'h200;
        step();
        flush = 1'b0;
        chk("fw_pc", pc_out, 32'h200);
        chk("fw_valid", 32'(bus.if_valid), 32'd0);
        chk("fw_req_drain", 32'(bus.imem_req), 32'd0);
        step();
        chk("fw_req_drain2", 32'(bus.imem_req), 32'd0);
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata = 32'hDEADBEEF;
        step();
        bus.imem_rvalid = 1'b0;
        chk("fw_valid_after", 32'(bus.if_valid), 32'd0);
        chk("fw_req_new", 32'(bus.imem_req), 32'd1);
        chk("fw_addr_new", bus.imem_addr, 32'h200);
        fetch_one(32'h200, 32'h1000_0200, 0, 0, 1'b0, 32'h0);

        // Flush and id_ready in the same HOLD cycle
        fetch_to_hold(32'h204, 32'h1000_0204, 0);
        bus.id_ready = 1'b1;
        flush = 1'b1;
        flush_pc = 32'h300;
        step();
        bus.id_ready = 1'b0;
        flush = 1'b0;
        void'(sb.pop_front());
        chk("fh_count", fetch_count, exp_count);
        chk("fh_pc", pc_out, 32'h300);
        chk("fh_valid", 32'(bus.if_valid), 32'd0);
        chk("fh_req", 32'(bus.imem_req), 32'd1);
        fetch_one(32'h300, 32'h1000_0300, 0, 0, 1'b0, 32'h0);
        chk("stale_never_valid", 32'(saw_stale), 32'd0);

        // Asynchronous reset while holding an instruction
        fetch_to_hold(32'h304, 32'h1000_0304, 0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(bus.if_valid), 32'd0);
        chk("ar_pc", pc_out, 32'h0);
        chk("ar_count", fetch_count, 32'h0);
        chk("ar_req", 32'(bus.imem_req), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        exp_count = 0;
        fetch_one(32'h0, 32'h2000_0000, 0, 0, 1'b0, 32'h0);
        chk("sb_empty_end", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
